// File: rtl/ext_irq_controller.sv
// Requesting end of the ExtIRQ/ExtIAck four-phase handshake: latches source edges,
// serves the lowest-index unmasked pending source, then holds a quiet gap before the next request.
module ext_irq_controller #(
    parameter int             N          = 64,
    parameter int             NSRC       = 4,
    parameter logic [N-1:0]   CAUSE_BASE = 'h10,
    parameter int             GAP        = 8
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic [NSRC-1:0] irq_mask,
    input  logic            ExtIAck,
    output logic            ExtIRQ,
    output logic [N-1:0]    irq_cause,
    output logic [NSRC-1:0] irq_pending,
    output logic [15:0]     irq_count,
    output logic            spurious_ack
);
    localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

    state_t           state, state_next;
    logic [NSRC-1:0]  src_q, pending, pending_next;
    logic [NSRC-1:0]  rise, clr, selectable;
    logic [SEL_W-1:0] sel, sel_next, sel_idx;
    logic             sel_found;
    logic [7:0]       gap_cnt, gap_next;
    logic             irq_next, spurious_next;
    logic [N-1:0]     cause_next;
    logic [15:0]      count_next;

    assign irq_pending = pending;

    always_comb begin
        rise          = irq_src & ~src_q;
        selectable    = pending & ~irq_mask;
        sel_found     = 1'b0;
        sel_idx       = '0;
        state_next    = state;
        sel_next      = sel;
        gap_next      = gap_cnt;
        irq_next      = ExtIRQ;
        cause_next    = irq_cause;
        count_next    = irq_count;
        spurious_next = 1'b0;
        clr           = '0;

        // Scanning downward leaves the lowest selectable index as the winner.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (selectable[i]) begin
                sel_found = 1'b1;
                sel_idx   = SEL_W'(i);
            end
        end

        case (state)
            IDLE: begin
                spurious_next = ExtIAck;
                if (gap_cnt != 8'd0) begin
                    gap_next = gap_cnt - 8'd1;
                end else if (sel_found) begin
                    sel_next   = sel_idx;
                    cause_next = CAUSE_BASE + N'(sel_idx);
                    irq_next   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (ExtIAck) begin
                    clr        = NSRC'(1) << sel;
                    irq_next   = 1'b0;
                    cause_next = '0;
                    count_next = irq_count + 16'd1;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!ExtIAck) begin
                    gap_next   = 8'(GAP);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // A fresh edge on the bit being acknowledged wins over the clear.
        pending_next = (pending & ~clr) | rise;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state        <= IDLE;
            src_q        <= '0;
            pending      <= '0;
            sel          <= '0;
            gap_cnt      <= 8'd0;
            ExtIRQ       <= 1'b0;
            irq_cause    <= '0;
            irq_count    <= 16'd0;
            spurious_ack <= 1'b0;
        end else begin
            state        <= state_next;
            src_q        <= irq_src;
            pending      <= pending_next;
            sel          <= sel_next;
            gap_cnt      <= gap_next;
            ExtIRQ       <= irq_next;
            irq_cause    <= cause_next;
            irq_count    <= count_next;
            spurious_ack <= spurious_next;
        end
    end

endmodule

// File: tb/tb_ext_irq_controller.sv
// Bench for ext_irq_controller: directed handshake scenarios followed by random traffic,
// each cycle compared against a transaction-level model of the request/ack protocol.
module tb_ext_irq_controller;
    localparam int NSRC = 4;
    localparam int N    = 64;
    localparam int GAP  = 8;

    logic            CLOCK_50;
    logic            reset;
    logic [NSRC-1:0] irq_src;
    logic [NSRC-1:0] irq_mask;
    logic            ExtIAck;
    logic            ExtIRQ;
    logic [N-1:0]    irq_cause;
    logic [NSRC-1:0] irq_pending;
    logic [15:0]     irq_count;
    logic            spurious_ack;

    int checks = 0;
    int errors = 0;

    // Reference model: a request outstanding for one source, or waiting for the ack to drop,
    // or idle with a number of quiet cycles still to serve.
    bit              m_req;
    bit              m_wait_drop;
    int              m_quiet;
    int              m_sel;
    int              m_count;
    bit              m_spur;
    logic [NSRC-1:0] m_pend;
    logic [NSRC-1:0] m_prev;

    ext_irq_controller #(
        .N(N), .NSRC(NSRC), .CAUSE_BASE(64'h10), .GAP(GAP)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .irq_src(irq_src),
        .irq_mask(irq_mask),
        .ExtIAck(ExtIAck),
        .ExtIRQ(ExtIRQ),
        .irq_cause(irq_cause),
        .irq_pending(irq_pending),
        .irq_count(irq_count),
        .spurious_ack(spurious_ack)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelStep(input logic [NSRC-1:0] src, input logic [NSRC-1:0] mask,
                             input bit ack, input bit rst_n);
        int              clear_idx;
        logic [NSRC-1:0] rises;
        clear_idx = -1;
        m_spur    = 1'b0;
        if (!rst_n) begin
            m_req       = 1'b0;
            m_wait_drop = 1'b0;
            m_quiet     = 0;
            m_sel       = 0;
            m_count     = 0;
            m_pend      = '0;
            m_prev      = '0;
        end else begin
            rises = src & ~m_prev;
            if (m_req) begin
                if (ack) begin
                    clear_idx   = m_sel;
                    m_req       = 1'b0;
                    m_wait_drop = 1'b1;
                    m_count     = (m_count + 1) % 65536;
                end
            end else if (m_wait_drop) begin
                if (!ack) begin
                    m_wait_drop = 1'b0;
                    m_quiet     = GAP;
                end
            end else begin
                m_spur = ack;
                if (m_quiet > 0) begin
                    m_quiet--;
                end else begin
                    for (int i = 0; i < NSRC; i++) begin
                        if (m_pend[i] && !mask[i]) begin
                            m_sel = i;
                            m_req = 1'b1;
                            break;
                        end
                    end
                end
            end
            if (clear_idx >= 0) m_pend[clear_idx] = 1'b0;
            m_pend = m_pend | rises;
            m_prev = src;
        end
    endtask

    task automatic checkOutput();
        check("ExtIRQ", ExtIRQ, 64'(m_req));
        check("irq_cause", irq_cause, m_req ? 64'h10 + 64'(m_sel) : 64'h0);
        check("irq_pending", irq_pending, 64'(m_pend));
        check("irq_count", irq_count, 64'(m_count));
        check("spurious_ack", spurious_ack, 64'(m_spur));
    endtask

    // ack_mode: 0 = low, 1 = high, 2 = follow the request line (processor acks at once)
    task automatic applyStimulus(input logic [NSRC-1:0] src, input logic [NSRC-1:0] mask,
                                 input int ack_mode, input bit rst_n);
        bit ack;
        ack      = (ack_mode == 2) ? m_req : (ack_mode != 0);
        irq_src  = src;
        irq_mask = mask;
        ExtIAck  = ack;
        reset    = rst_n;
        @(posedge CLOCK_50);
        modelStep(src, mask, ack, rst_n);
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(4'b0000, 4'b0000, 2, 1'b1);
    endtask

    initial begin
        logic [NSRC-1:0] rsrc;
        logic [NSRC-1:0] rmask;
        int              ackm;
        bit              rst;

        m_req = 1'b0; m_wait_drop = 1'b0; m_quiet = 0; m_sel = 0; m_count = 0;
        m_spur = 1'b0; m_pend = '0; m_prev = '0;
        irq_src = '0; irq_mask = '0; ExtIAck = 1'b0; reset = 1'b0;
        #1;

        // Reset with no stimulus
        applyStimulus(4'b0000, 4'b0000, 0, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 0, 1'b0);
        check("rst_irq", ExtIRQ, 64'd0);
        check("rst_cause", irq_cause, 64'd0);
        check("rst_pend", irq_pending, 64'd0);
        check("rst_count", irq_count, 64'd0);

        // Single source, processor acks immediately
        applyStimulus(4'b0100, 4'b0000, 2, 1'b1);
        check("s2_pend_set", irq_pending, 64'b0100);
        check("s2_irq_t0", ExtIRQ, 64'd0);
        applyStimulus(4'b0100, 4'b0000, 2, 1'b1);
        check("s2_irq_rise", ExtIRQ, 64'd1);
        check("s2_cause", irq_cause, 64'h12);
        applyStimulus(4'b0100, 4'b0000, 2, 1'b1);
        check("s2_irq_drop", ExtIRQ, 64'd0);
        check("s2_count", irq_count, 64'd1);
        check("s2_pend_clr", irq_pending, 64'd0);
        idle(10);

        // Two simultaneous sources: priority then gap
        applyStimulus(4'b1010, 4'b0000, 2, 1'b1);
        check("s3_pend", irq_pending, 64'b1010);
        applyStimulus(4'b1010, 4'b0000, 2, 1'b1);
        check("s3_first_irq", ExtIRQ, 64'd1);
        check("s3_first_cause", irq_cause, 64'h11);
        applyStimulus(4'b1010, 4'b0000, 2, 1'b1);
        check("s3_count1", irq_count, 64'd2);
        check("s3_pend_left", irq_pending, 64'b1000);
        repeat (9) begin
            applyStimulus(4'b1010, 4'b0000, 2, 1'b1);
            check("s3_gap_quiet", ExtIRQ, 64'd0);
        end
        applyStimulus(4'b1010, 4'b0000, 2, 1'b1);
        check("s3_second_irq", ExtIRQ, 64'd1);
        check("s3_second_cause", irq_cause, 64'h13);
        applyStimulus(4'b1010, 4'b0000, 2, 1'b1);
        check("s3_count2", irq_count, 64'd3);
        idle(10);

        // Masked source stays pending until unmasked
        applyStimulus(4'b0001, 4'b0001, 2, 1'b1);
        check("s4_pend", irq_pending, 64'b0001);
        repeat (3) begin
            applyStimulus(4'b0001, 4'b0001, 2, 1'b1);
            check("s4_masked_quiet", ExtIRQ, 64'd0);
        end
        applyStimulus(4'b0001, 4'b0000, 2, 1'b1);
        check("s4_unmask_irq", ExtIRQ, 64'd1);
        check("s4_cause", irq_cause, 64'h10);

        // Ack held high parks in release; ack in idle is spurious
        applyStimulus(4'b0001, 4'b0000, 1, 1'b1);
        check("s5_count", irq_count, 64'd4);
        repeat (5) begin
            applyStimulus(4'b0001, 4'b0000, 1, 1'b1);
            check("s5_hold_irq", ExtIRQ, 64'd0);
            check("s5_hold_spur", spurious_ack, 64'd0);
        end
        applyStimulus(4'b0001, 4'b0000, 0, 1'b1);
        applyStimulus(4'b0001, 4'b0000, 1, 1'b1);
        check("s5_spur_pulse", spurious_ack, 64'd1);
        applyStimulus(4'b0001, 4'b0000, 0, 1'b1);
        check("s5_spur_end", spurious_ack, 64'd0);
        idle(10);

        // Re-edge on the ack cycle survives the clear; reset mid-request
        applyStimulus(4'b0001, 4'b0000, 2, 1'b1);
        applyStimulus(4'b0000, 4'b0000, 2, 1'b1);
        check("s6_irq", ExtIRQ, 64'd1);
        applyStimulus(4'b0001, 4'b0000, 2, 1'b1);
        check("s6_pend_kept", irq_pending, 64'b0001);
        check("s6_count", irq_count, 64'd5);
        repeat (9) begin
            applyStimulus(4'b0001, 4'b0000, 2, 1'b1);
            check("s6_gap_quiet", ExtIRQ, 64'd0);
        end
        applyStimulus(4'b0001, 4'b0000, 2, 1'b1);
        check("s6_reissue", ExtIRQ, 64'd1);
        applyStimulus(4'b0001, 4'b0000, 2, 1'b0);
        check("s6_rst_irq", ExtIRQ, 64'd0);
        check("s6_rst_pend", irq_pending, 64'd0);
        check("s6_rst_count", irq_count, 64'd0);

        // Random traffic against the model
        rsrc  = '0;
        rmask = '0;
        for (int k = 0; k < 1500; k++) begin
            for (int b = 0; b < NSRC; b++) begin
                if ($urandom_range(0, 5) == 0) rsrc[b] = ~rsrc[b];
            end
            if ($urandom_range(0, 30) == 0) begin
                rmask = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            end
            if (m_req)
                ackm = ($urandom_range(0, 2) == 0) ? 1 : 0;
            else if (m_wait_drop)
                ackm = int'($urandom_range(0, 1));
            else
                ackm = ($urandom_range(0, 9) == 0) ? 1 : 0;
            rst = ($urandom_range(0, 299) != 0);
            applyStimulus(rsrc, rmask, ackm, rst);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
